// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DEF_AW = 8;
   localparam int unsigned DEF_DW = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } arb_state_t;

   // One memory access at the default bus widths.
   typedef struct packed {
      logic              we;
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] wdata;
   } mem_req_t;

   // In-flight read marker: slot 0 = older, slot 1 = younger.
   // zero forces the returned data to 0 when the access was suppressed.
   typedef struct packed {
      logic valid;
      logic slot;
      logic zero;
   } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Slot request / memory port bundle for dmem_port_arbiter.
// Optional macro: MEM_BOUND_CHECK_EN adds the bound_err signal.
interface dmem_port_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
);
   logic             req0;
   logic             req1;
   logic             we0;
   logic             we1;
   logic [AW-1:0]    addr0;
   logic [AW-1:0]    addr1;
   logic [DW-1:0]    wdata0;
   logic [DW-1:0]    wdata1;
   logic             stall;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_data;
   logic             mem_rden;
   logic             mem_wren;
   logic [DW-1:0]    mem_q;
   logic             rvalid0;
   logic             rvalid1;
   logic [DW-1:0]    rdata0;
   logic [DW-1:0]    rdata1;
   logic [CNT_W-1:0] conflict_cnt;
`ifdef MEM_BOUND_CHECK_EN
   logic             bound_err;
`endif

   // Arbiter side.
   modport master (
`ifdef MEM_BOUND_CHECK_EN
      output bound_err,
`endif
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
      output stall, mem_addr, mem_data, mem_rden, mem_wren,
      output rvalid0, rvalid1, rdata0, rdata1, conflict_cnt
   );

   // Core / memory side.
   modport slave (
`ifdef MEM_BOUND_CHECK_EN
      input  bound_err,
`endif
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
      input  stall, mem_addr, mem_data, mem_rden, mem_wren,
      input  rvalid0, rvalid1, rdata0, rdata1, conflict_cnt
   );

endinterface

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags until mem_q is valid.
module rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
)(
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);
   rd_tag_t r_stage [DEPTH];

   // Shift one stage per cycle; reset drops every in-flight tag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage <= '{default: '0};
      end else begin
         r_stage[0] <= i_tag;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises the two issue slots onto one data-memory port in program
// order, stalls the front end for the extra cycle, steers read data back.
// Optional macro: MEM_BOUND_CHECK_EN suppresses accesses at or above
// MEM_DEPTH and reports them on bound_err.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned MEM_DEPTH = 256
)(
   input logic                 clk,
   input logic                 reset,
   dmem_port_arbiter_if.master io_bus
);
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } hold_t;

   // Out-of-range configurations elaborate this empty scope only.
   if (RD_LAT == 0 || RD_LAT > 4 || MEM_DEPTH == 0) begin : g_illegal_cfg
   end

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   hold_t            r_hold;
   logic [CNT_W-1:0] r_conflict_cnt;
   logic             r_rvalid0;
   logic             r_rvalid1;
   logic [DW-1:0]    r_rdata0;
   logic [DW-1:0]    r_rdata1;

   logic             w_issue;
   logic             w_issue_we;
   logic             w_issue_slot;
   logic [AW-1:0]    w_issue_addr;
   logic [DW-1:0]    w_issue_data;
   logic             w_stall;
   logic             w_capture;
   logic             w_oob;
   rd_tag_t          w_tag_in;
   rd_tag_t          w_tag_out;
   logic [DW-1:0]    w_rd_val;

   // Next-state and issue selection; everything is gated off while in reset.
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_issue_we   = 1'b0;
      w_issue_slot = 1'b0;
      w_issue_addr = '0;
      w_issue_data = '0;
      w_stall      = 1'b0;
      w_capture    = 1'b0;
      if (reset) begin
         unique case (r_state)
            IDLE: begin
               if (io_bus.req0) begin
                  w_issue      = 1'b1;
                  w_issue_we   = io_bus.we0;
                  w_issue_addr = io_bus.addr0;
                  w_issue_data = io_bus.wdata0;
                  if (io_bus.req1) begin
                     w_stall     = 1'b1;
                     w_capture   = 1'b1;
                     w_state_nxt = SECOND;
                  end
               end else if (io_bus.req1) begin
                  w_issue      = 1'b1;
                  w_issue_we   = io_bus.we1;
                  w_issue_slot = 1'b1;
                  w_issue_addr = io_bus.addr1;
                  w_issue_data = io_bus.wdata1;
               end
            end
            SECOND: begin
               w_issue      = 1'b1;
               w_issue_we   = r_hold.we;
               w_issue_slot = 1'b1;
               w_issue_addr = r_hold.addr;
               w_issue_data = r_hold.wdata;
               w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

`ifdef MEM_BOUND_CHECK_EN
   logic r_bound_err;

   assign w_oob = w_issue && (32'(w_issue_addr) >= 32'(MEM_DEPTH));

   // Flag a suppressed access in the cycle after it was issued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_bound_err <= 1'b0;
      else        r_bound_err <= w_oob;
   end

   assign io_bus.bound_err = r_bound_err;
`else
   assign w_oob = 1'b0;
`endif

   assign io_bus.mem_addr = w_issue_addr;
   assign io_bus.mem_data = w_issue_data;
   assign io_bus.mem_rden = w_issue && !w_issue_we && !w_oob;
   assign io_bus.mem_wren = w_issue && w_issue_we && !w_oob;
   assign io_bus.stall    = w_stall;

   // Suppressed reads still carry a tag so the requester gets a response.
   assign w_tag_in = '{valid: w_issue && !w_issue_we, slot: w_issue_slot, zero: w_oob};

   rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_tag   (w_tag_in),
      .o_tag   (w_tag_out)
   );

   assign w_rd_val = w_tag_out.zero ? '0 : io_bus.mem_q;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Hold the younger slot's access while the older one uses the port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold <= '0;
      end else if (w_capture) begin
         r_hold <= '{we: io_bus.we1, addr: io_bus.addr1, wdata: io_bus.wdata1};
      end
   end

   // Saturating count of dual-request cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conflict_cnt <= '0;
      end else if (w_capture && (r_conflict_cnt != '1)) begin
         r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
   end

   // Register the returning read into the owning slot; the other slot holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_tag_out.valid && !w_tag_out.slot;
         r_rvalid1 <= w_tag_out.valid && w_tag_out.slot;
         if (w_tag_out.valid && !w_tag_out.slot) r_rdata0 <= w_rd_val;
         if (w_tag_out.valid && w_tag_out.slot)  r_rdata1 <= w_rd_val;
      end
   end

   assign io_bus.rvalid0      = r_rvalid0;
   assign io_bus.rvalid1      = r_rvalid1;
   assign io_bus.rdata0       = r_rdata0;
   assign io_bus.rdata1       = r_rdata1;
   assign io_bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter (RD_LAT=1).
// Optional macro: MEM_BOUND_CHECK_EN enables the bound-check vectors.
module tb_dmem_port_arbiter;
   localparam int unsigned TB_RD_LAT = 1;
`ifdef MEM_BOUND_CHECK_EN
   localparam int unsigned TB_DEPTH = 128;
`else
   localparam int unsigned TB_DEPTH = 256;
`endif
   localparam int LAT = 2;   // issue to rvalid: RD_LAT + 1

   typedef struct {
      int          slot;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   logic [31:0] mem [256];
   logic [31:0] q_pipe [TB_RD_LAT];
   bit          mem_ready = 1'b0;

   dmem_port_arbiter_if #(.AW(8), .DW(32)) u_if ();

   dmem_port_arbiter #(
      .AW        (8),
      .DW        (32),
      .RD_LAT    (TB_RD_LAT),
      .MEM_DEPTH (TB_DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (rst_n),
      .io_bus (u_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read-before-write, RD_LAT register stages on mem_q.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[8'h10] <= 32'hDEADBEEF;
         mem_ready  <= 1'b1;
      end else if (u_if.mem_wren) begin
         mem[u_if.mem_addr] <= u_if.mem_data;
      end
      q_pipe[0] <= u_if.mem_rden ? mem[u_if.mem_addr] : 32'hxxxx_xxxx;
      for (int k = 1; k < int'(TB_RD_LAT); k++) q_pipe[k] <= q_pipe[k-1];
   end
   assign u_if.mem_q = q_pipe[TB_RD_LAT-1];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Monitor: every rvalid pops one expectation.
   always @(negedge clk) begin
      if (u_if.rvalid0 && u_if.rvalid1) chk("rvalid_both", 32'd1, 32'd0);
      if (u_if.rvalid0 || u_if.rvalid1) begin
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", {31'd0, u_if.rvalid1}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rv_slot", u_if.rvalid1 ? 32'd1 : 32'd0, 32'(e.slot));
            chk("rv_data", u_if.rvalid1 ? u_if.rdata1 : u_if.rdata0, e.data);
            chk("rv_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_in(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
      u_if.req0 = r0; u_if.we0 = w0; u_if.addr0 = a0; u_if.wdata0 = d0;
      u_if.req1 = r1; u_if.we1 = w1; u_if.addr1 = a1; u_if.wdata1 = d1;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic push(input int slot, input logic [31:0] data, input int at);
      exp_t e;
      e.slot = slot; e.data = data; e.cyc = at;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0]  p_a0 [3];
      logic [7:0]  p_a1 [3];
      logic [31:0] p_d0 [3];
      logic [31:0] p_d1 [3];
      logic [15:0] sat_exp [3];
      p_a0 = '{8'h30, 8'h32, 8'h34};
      p_a1 = '{8'h31, 8'h33, 8'h35};
      p_d0 = '{32'hA500_0030, 32'hA500_0032, 32'hA500_0034};
      p_d1 = '{32'hA500_0031, 32'hA500_0033, 32'hA500_0035};
      sat_exp = '{16'hFFFE, 16'hFFFF, 16'hFFFF};

      idle();
      repeat (2) step();
      settle();
      chk("rst_stall", {31'd0, u_if.stall}, 32'd0);
      chk("rst_rden", {31'd0, u_if.mem_rden}, 32'd0);
      chk("rst_wren", {31'd0, u_if.mem_wren}, 32'd0);
      chk("rst_addr", {24'd0, u_if.mem_addr}, 32'd0);
      chk("rst_data", u_if.mem_data, 32'd0);
      chk("rst_rvalid", {30'd0, u_if.rvalid1, u_if.rvalid0}, 32'd0);
      chk("rst_rdata0", u_if.rdata0, 32'd0);
      chk("rst_rdata1", u_if.rdata1, 32'd0);
      chk("rst_cnt", {16'd0, u_if.conflict_cnt}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // Single load, slot 0.
      set_in(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      settle();
      chk("t1_rden", {31'd0, u_if.mem_rden}, 32'd1);
      chk("t1_wren", {31'd0, u_if.mem_wren}, 32'd0);
      chk("t1_addr", {24'd0, u_if.mem_addr}, 32'h10);
      chk("t1_stall", {31'd0, u_if.stall}, 32'd0);
      push(0, 32'hDEADBEEF, cyc + LAT);
      step();
      idle();
      settle();
      chk("t1_rden_off", {31'd0, u_if.mem_rden}, 32'd0);
      chk("t1_stall2", {31'd0, u_if.stall}, 32'd0);
      repeat (3) step();

      // store0 / load1 to the same address.
      set_in(1'b1, 1'b1, 8'h20, 32'h12345678, 1'b1, 1'b0, 8'h20, 32'h0);
      settle();
      chk("t2_wren", {31'd0, u_if.mem_wren}, 32'd1);
      chk("t2_rden0", {31'd0, u_if.mem_rden}, 32'd0);
      chk("t2_addr0", {24'd0, u_if.mem_addr}, 32'h20);
      chk("t2_data0", u_if.mem_data, 32'h12345678);
      chk("t2_stall0", {31'd0, u_if.stall}, 32'd1);
      step();
      settle();
      chk("t2_rden1", {31'd0, u_if.mem_rden}, 32'd1);
      chk("t2_wren1", {31'd0, u_if.mem_wren}, 32'd0);
      chk("t2_addr1", {24'd0, u_if.mem_addr}, 32'h20);
      chk("t2_stall1", {31'd0, u_if.stall}, 32'd0);
      push(1, 32'h12345678, cyc + LAT);
      idle();
      step();
      settle();
      chk("t2_cnt", {16'd0, u_if.conflict_cnt}, 32'd1);
      repeat (3) step();

      // Three back-to-back dual loads.
      set_in(1'b1, 1'b0, p_a0[0], 32'h0, 1'b1, 1'b0, p_a1[0], 32'h0);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t3_stall_hi", {31'd0, u_if.stall}, 32'd1);
         chk("t3_addr0", {24'd0, u_if.mem_addr}, {24'd0, p_a0[k]});
         chk("t3_rden0", {31'd0, u_if.mem_rden}, 32'd1);
         push(0, p_d0[k], cyc + LAT);
         step();
         settle();
         chk("t3_stall_lo", {31'd0, u_if.stall}, 32'd0);
         chk("t3_addr1", {24'd0, u_if.mem_addr}, {24'd0, p_a1[k]});
         chk("t3_rden1", {31'd0, u_if.mem_rden}, 32'd1);
         push(1, p_d1[k], cyc + LAT);
         if (k < 2) set_in(1'b1, 1'b0, p_a0[k+1], 32'h0, 1'b1, 1'b0, p_a1[k+1], 32'h0);
         else       idle();
         step();
      end
      settle();
      chk("t3_stall_end", {31'd0, u_if.stall}, 32'd0);
      chk("t3_cnt", {16'd0, u_if.conflict_cnt}, 32'd4);
      repeat (3) step();

      // Reset while in SECOND with the slot-0 read in flight.
      set_in(1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b0, 8'h41, 32'h0);
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("t4_stall", {31'd0, u_if.stall}, 32'd0);
      chk("t4_rden", {31'd0, u_if.mem_rden}, 32'd0);
      chk("t4_addr", {24'd0, u_if.mem_addr}, 32'd0);
      chk("t4_rvalid", {30'd0, u_if.rvalid1, u_if.rvalid0}, 32'd0);
      chk("t4_cnt", {16'd0, u_if.conflict_cnt}, 32'd0);
      idle();
      repeat (3) step();
      @(negedge clk) rst_n = 1'b1;
      step();
      set_in(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
      settle();
      chk("t4_post_rden", {31'd0, u_if.mem_rden}, 32'd1);
      chk("t4_post_addr", {24'd0, u_if.mem_addr}, 32'h10);
      push(1, 32'hDEADBEEF, cyc + LAT);
      step();
      idle();
      repeat (4) step();

      // Counter saturation from a preloaded value.
      force dut.r_conflict_cnt = 16'hFFFD;
      #1;
      release dut.r_conflict_cnt;
      step();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 1'b1, 8'h50, 32'h0000_0050, 1'b1, 1'b1, 8'h51, 32'h0000_0051);
         step();
         settle();
         chk("t5_cnt", {16'd0, u_if.conflict_cnt}, {16'd0, sat_exp[k]});
         idle();
         step();
      end

`ifdef MEM_BOUND_CHECK_EN
      // Out-of-range load is suppressed but still answered with zero.
      set_in(1'b1, 1'b0, 8'h90, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      settle();
      chk("t6_rden", {31'd0, u_if.mem_rden}, 32'd0);
      chk("t6_wren", {31'd0, u_if.mem_wren}, 32'd0);
      push(0, 32'h0, cyc + LAT);
      step();
      idle();
      settle();
      chk("t6_berr_hi", {31'd0, u_if.bound_err}, 32'd1);
      step();
      settle();
      chk("t6_berr_lo", {31'd0, u_if.bound_err}, 32'd0);
`endif

      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      step();
      chk("drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the two issue slots of the dual-issue core.
- Slot 0 is the older instruction and slot 1 the younger, in program order.
- When both slots need memory in the same cycle, the block serializes them in program order, stalls the front end for one cycle, and steers read data back to the requesting slot.
- Sits between the two EX-stage ALU address outputs and the dataMemory instance.

Parameters:
- AW, 8, memory address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from a read issue (mem_rden high) to valid mem_q; legal range 1..4.
- MEM_DEPTH, 256, number of valid words; used only when MEM_BOUND_CHECK_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  slot requests a memory access this cycle.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  DW  store data.
- stall  out  1  holds PC and slot pipeline registers for this cycle.
- mem_addr  out  AW  address to dataMemory.
- mem_data  out  DW  write data to dataMemory.
- mem_rden / mem_wren  out  1  memory read / write enables.
- mem_q  in  DW  memory read data.
- rvalid0 / rvalid1  out  1  read data valid for the slot.
- rdata0 / rdata1  out  DW  read data for the slot.
- conflict_cnt  out  16  saturating count of dual-request cycles.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - stall=0, mem_rden=0, mem_wren=0.
  - mem_addr=0, mem_data=0.
  - rvalid0/1=0, rdata0/1=0.
  - tag pipeline cleared; conflict_cnt=0.
- Reset mid-operation discards the captured slot-1 request and all in-flight read tags. No rvalid is produced after reset for any request issued before it.
- Port outputs mem_* are combinational from the current state and inputs.
- FSM states: IDLE, SECOND.
- IDLE:
  - Neither request: mem enables 0.
  - Exactly one request: issue that slot's access this cycle; stall=0; stay in IDLE.
  - Both requests:
    - Issue slot 0 this cycle.
    - stall=1 (combinational, same cycle).
    - Capture we1/addr1/wdata1 into a holding register.
    - conflict_cnt += 1 (saturates at 16'hFFFF).
    - Go to SECOND.
- SECOND:
  - Issue the captured slot-1 access, ignoring the current inputs (the pipeline is held, so they repeat).
  - stall=0; return to IDLE.
  - Not a new conflict; the counter does not increment.
- Program order is always slot 0 then slot 1. A same-address store0/load1 pair therefore returns the newly stored value. No forwarding logic is required.
- Read return:
  - Each issued read pushes a tag (valid, slot id) into an RD_LAT-deep shift register.
  - When a tag exits, rvalidN=1 for exactly one cycle, with rdataN = mem_q registered on that edge.
  - Total latency is RD_LAT+1 cycles from issue to rvalid.
  - The other slot's rvalid is 0 and its rdata holds its last value.
- Stores produce no rvalid.
- Back-to-back conflicts give a throughput of one access per cycle; stall is high on every other cycle.

Optional Feature:
- Macro: MEM_BOUND_CHECK_EN.
- Defined:
  - Any issued access with addr >= MEM_DEPTH is suppressed (mem_rden=mem_wren=0).
  - Output bound_err (1 bit) is registered high for one cycle, the cycle after issue.
  - A suppressed read still produces rvalid with rdata=0, so the pipeline never hangs.
- Undefined: the bound_err port does not exist; addresses are passed unchecked.

Decomposition:
- Package dmem_arb_pkg:
  - Typedef arb_state_t {IDLE, SECOND}.
  - Typedef mem_req_t {we, addr, wdata}.
  - Constant CNT_W=16.
- Sub-module rd_tag_pipe: RD_LAT-deep shift of {valid, slot}, with synchronous shift and async clear. It is the only natural split.

Test Plan:
1. Single load, slot 0, addr0=8'h10, memory[8'h10]=32'hDEADBEEF, RD_LAT=1 -> mem_rden pulses in cycle 0; rvalid0=1 with rdata0=32'hDEADBEEF at cycle 2; stall never asserted.
2. Dual request: store0 addr 8'h20 data 32'h12345678 with load1 addr 8'h20 -> cycle 0: wren, stall=1; cycle 1: rden addr 8'h20, stall=0; rvalid1 with 32'h12345678; conflict_cnt=1.
3. Three consecutive dual-load pairs -> stall pattern 1,0,1,0,1,0; six rvalids alternating slot 0/slot 1 in order; conflict_cnt=3.
4. Reset asserted in SECOND state with a read in flight -> all outputs 0 immediately (async); no rvalid after release; next single request serviced normally.
5. conflict_cnt preloaded near 16'hFFFE via 3 forced conflicts -> saturates at 16'hFFFF and holds.
6. With MEM_BOUND_CHECK_EN, MEM_DEPTH=128, load addr 8'h90 -> no mem_rden; bound_err=1 one cycle later; rvalid0 with rdata0=0.
